// File: rtl/mips_data_ram_pkg.sv
// Shared encodings for the MIPS data RAM: access sizes, FSM states and alignment rules.
package mips_data_ram_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_size_t;

    // One-hot encoding so the two unused patterns exist and can fall back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_RMW  = 2'b10
    } state_t;

    function automatic logic misaligned(input mem_size_t size, input logic [1:0] lane);
        case (size)
            MEM_HALF: return lane[0];
            MEM_WORD: return |lane;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_data_ram_byte_lane.sv
// Big-endian lane steering: extracts right-aligned load data and merges store data into a word.
module mips_byte_lane
    import mips_data_ram_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  mem_size_t   size,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    always_comb begin
        extracted = 32'h0;
        merged    = word;
        case (size)
            MEM_BYTE: begin
                case (lane)
                    2'd0: begin extracted = {24'h0, word[31:24]}; merged[31:24] = data[7:0]; end
                    2'd1: begin extracted = {24'h0, word[23:16]}; merged[23:16] = data[7:0]; end
                    2'd2: begin extracted = {24'h0, word[15:8]};  merged[15:8]  = data[7:0]; end
                    default: begin extracted = {24'h0, word[7:0]}; merged[7:0] = data[7:0]; end
                endcase
            end
            MEM_HALF: begin
                if (lane[1]) begin
                    extracted    = {16'h0, word[15:0]};
                    merged[15:0] = data[15:0];
                end else begin
                    extracted     = {16'h0, word[31:16]};
                    merged[31:16] = data[15:0];
                end
            end
            MEM_WORD: begin
                extracted = word;
                merged    = data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_data_ram.sv
// Single-port word RAM behind the processor data port; sub-word stores take a two-cycle
// read-modify-write, loads return one cycle after the request edge.
module mips_data_ram
    import mips_data_ram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] MemAddr,
    input  logic [31:0] DataMemIn,
    input  logic [1:0]  MemRead,
    input  logic [1:0]  MemWrite,
    output logic [31:0] DataMemOut,
    output logic        MemBusy,
    output logic        MemFault
);

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx, idx_q;
    logic [1:0]        lane_q;
    mem_size_t         size_q, req_size;
    logic [31:0]       data_q, hold_q, out_q;
    logic              fault_q;

    logic rd_req, wr_req, out_of_range, req_fault, idle;
    logic do_load, do_word_store, do_rmw_start;

    logic [31:0]       lane_word, extracted, merged;
    logic [1:0]        lane_sel;
    mem_size_t         size_sel;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;

    assign idx          = MemAddr[ADDR_W+1:2];
    assign out_of_range = |MemAddr[31:ADDR_W+2];
    assign rd_req       = (MemRead != 2'b00);
    assign wr_req       = (MemWrite != 2'b00);
    assign req_size     = mem_size_t'(rd_req ? MemRead : MemWrite);
    assign req_fault    = (rd_req && wr_req) ||
                          ((rd_req || wr_req) && (out_of_range || misaligned(req_size, MemAddr[1:0])));
    assign idle         = (state_q == ST_IDLE);

    // A legal write implies no read is present, since conflicts are faults.
    assign do_load       = idle && rd_req && !req_fault;
    assign do_word_store = idle && wr_req && !req_fault && (req_size == MEM_WORD);
    assign do_rmw_start  = idle && wr_req && !req_fault && (req_size != MEM_WORD);

    // The lane unit extracts from the live RAM word when idle and merges into hold_q during RMW.
    assign lane_word = idle ? ram[idx] : hold_q;
    assign lane_sel  = idle ? MemAddr[1:0] : lane_q;
    assign size_sel  = idle ? req_size : size_q;

    mips_byte_lane u_lane (
        .word      (lane_word),
        .data      (data_q),
        .lane      (lane_sel),
        .size      (size_sel),
        .extracted (extracted),
        .merged    (merged)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = do_rmw_start ? ST_RMW : ST_IDLE;
            ST_RMW:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        MemBusy   = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = idx;
        ram_wdata = DataMemIn;
        case (state_q)
            ST_IDLE: ram_we = do_word_store;
            ST_RMW: begin
                MemBusy   = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = idx_q;
                ram_wdata = merged;
            end
            default: ;
        endcase
        // Held reset must not let a stray store reach the array.
        if (!Reset) ram_we = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out_q   <= 32'h0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= MEM_NONE;
            data_q  <= 32'h0;
            hold_q  <= 32'h0;
        end else begin
            out_q   <= do_load ? extracted : 32'h0;
            fault_q <= idle && req_fault;
            if (do_rmw_start) begin
                idx_q  <= idx;
                lane_q <= MemAddr[1:0];
                size_q <= req_size;
                data_q <= DataMemIn;
                hold_q <= ram[idx];
            end
        end
    end

    assign DataMemOut = out_q;
    assign MemFault   = fault_q;

endmodule

// File: tb/tb_mips_data_ram.sv
// Directed bench for mips_data_ram: byte-addressed reference model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_mips_data_ram;

    logic        Clk;
    logic        Reset;
    logic [31:0] MemAddr;
    logic [31:0] DataMemIn;
    logic [1:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] DataMemOut;
    logic        MemBusy;
    logic        MemFault;

    int errors = 0;
    int checks = 0;

    mips_data_ram #(.ADDR_W(10)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MemAddr    (MemAddr),
        .DataMemIn  (DataMemIn),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .DataMemOut (DataMemOut),
        .MemBusy    (MemBusy),
        .MemFault   (MemFault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a 4 KiB byte array, big-endian, with a known-byte mask.
    logic [7:0]  mb [0:4095];
    bit          mk [0:4095];
    logic [31:0] exp_dout  = 32'h0;
    logic        exp_busy  = 1'b0;
    logic        exp_fault = 1'b0;
    bit          exp_known = 1'b1;
    bit          m_busy = 1'b0;
    int          p_a, p_n;
    logic [31:0] p_d;
    int          m_n, m_a;
    logic [1:0]  m_sz;
    logic [31:0] m_v;
    bit          m_kn;
    bit          cmp_en = 1'b0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_busy = 1'b0; exp_dout = 32'h0; exp_busy = 1'b0; exp_fault = 1'b0; exp_known = 1'b1;
        end else if (m_busy) begin
            for (int k = 0; k < p_n; k++) begin
                mb[p_a+k] = 8'(p_d >> (8*(p_n-1-k)));
                mk[p_a+k] = 1'b1;
            end
            m_busy = 1'b0; exp_dout = 32'h0; exp_busy = 1'b0; exp_fault = 1'b0; exp_known = 1'b1;
        end else begin
            exp_dout = 32'h0; exp_busy = 1'b0; exp_fault = 1'b0; exp_known = 1'b1;
            if (MemRead != 2'b00 || MemWrite != 2'b00) begin
                m_sz = (MemRead != 2'b00) ? MemRead : MemWrite;
                m_n  = 1 << (m_sz - 1);
                m_a  = int'(MemAddr[11:0]);
                if ((MemRead != 2'b00 && MemWrite != 2'b00) || (m_a % m_n) != 0 || MemAddr >= 32'd4096) begin
                    exp_fault = 1'b1;
                end else if (MemRead != 2'b00) begin
                    m_v = 32'h0; m_kn = 1'b1;
                    for (int k = 0; k < m_n; k++) begin
                        m_v = (m_v << 8) | 32'(mb[m_a+k]);
                        m_kn = m_kn && mk[m_a+k];
                    end
                    exp_dout = m_v; exp_known = m_kn;
                end else if (m_n == 4) begin
                    for (int k = 0; k < 4; k++) begin
                        mb[m_a+k] = 8'(DataMemIn >> (8*(3-k)));
                        mk[m_a+k] = 1'b1;
                    end
                end else begin
                    p_a = m_a; p_n = m_n; p_d = DataMemIn;
                    m_busy = 1'b1; exp_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("cyc_busy", {31'h0, MemBusy}, {31'h0, exp_busy});
            check("cyc_fault", {31'h0, MemFault}, {31'h0, exp_fault});
            if (exp_known) check("cyc_dout", DataMemOut, exp_dout);
        end
    end

    // Drive one request in the window after a posedge, then let the next edge sample it.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r, input logic [1:0] w);
        MemAddr = a; DataMemIn = d; MemRead = r; MemWrite = w;
        @(posedge Clk);
        #2;
        MemAddr = 32'h0; DataMemIn = 32'h0; MemRead = 2'b00; MemWrite = 2'b00;
    endtask

    task automatic idle_cycle();
        issue(32'h0, 32'h0, 2'b00, 2'b00);
    endtask

    logic [31:0] v;
    int          a;

    initial begin
        Reset = 1'b0; MemAddr = 32'h0; DataMemIn = 32'h0; MemRead = 2'b00; MemWrite = 2'b00;
        repeat (3) @(posedge Clk);
        #2;
        check("rst_dout", DataMemOut, 32'h0);
        check("rst_busy", {31'h0, MemBusy}, 32'h0);
        check("rst_fault", {31'h0, MemFault}, 32'h0);
        Reset = 1'b1;
        cmp_en = 1'b1;

        // Reset in the middle of a byte RMW leaves the target word untouched.
        issue(32'h10, 32'h01020304, 2'b00, 2'b11);
        issue(32'h10, 32'h000000AA, 2'b00, 2'b01);
        check("rmw_busy", {31'h0, MemBusy}, 32'h1);
        Reset = 1'b0;
        #1;
        check("rst_busy_now", {31'h0, MemBusy}, 32'h0);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        issue(32'h10, 32'h0, 2'b11, 2'b00);
        check("rst_rmw_word", DataMemOut, 32'h01020304);

        issue(32'h20, 32'hDEADBEEF, 2'b00, 2'b11);
        issue(32'h20, 32'h0, 2'b11, 2'b00);
        check("word_rdback", DataMemOut, 32'hDEADBEEF);

        // Byte RMW; a second byte store while busy is dropped.
        issue(32'h40, 32'h11223344, 2'b00, 2'b11);
        issue(32'h41, 32'h000000AA, 2'b00, 2'b01);
        check("byte_busy", {31'h0, MemBusy}, 32'h1);
        issue(32'h40, 32'h00000055, 2'b00, 2'b01);
        check("busy_clear", {31'h0, MemBusy}, 32'h0);
        issue(32'h40, 32'h0, 2'b11, 2'b00);
        check("byte_merge", DataMemOut, 32'h11AA3344);
        issue(32'h43, 32'h0, 2'b01, 2'b00);
        check("byte_load3", DataMemOut, 32'h00000044);
        issue(32'h41, 32'h0, 2'b01, 2'b00);
        check("byte_load1", DataMemOut, 32'h000000AA);

        issue(32'h40, 32'h00000000, 2'b00, 2'b11);
        issue(32'h42, 32'h0000BEEF, 2'b00, 2'b10);
        idle_cycle();
        issue(32'h40, 32'h0, 2'b11, 2'b00);
        check("half_merge", DataMemOut, 32'h0000BEEF);
        issue(32'h40, 32'h0, 2'b10, 2'b00);
        check("half_load0", DataMemOut, 32'h00000000);
        issue(32'h42, 32'h0, 2'b10, 2'b00);
        check("half_load2", DataMemOut, 32'h0000BEEF);
        issue(32'h42, 32'h0, 2'b01, 2'b00);
        check("byte_load2", DataMemOut, 32'h000000BE);

        // Faults must leave RAM alone and zero the output.
        issue(32'h30, 32'hCAFEF00D, 2'b00, 2'b11);
        issue(32'h00, 32'h12345678, 2'b00, 2'b11);
        issue(32'h22, 32'h0, 2'b11, 2'b00);
        check("flt_mis_word", {31'h0, MemFault}, 32'h1);
        check("flt_mis_dout", DataMemOut, 32'h0);
        issue(32'h31, 32'h00001234, 2'b00, 2'b10);
        check("flt_mis_half", {31'h0, MemFault}, 32'h1);
        check("flt_half_busy", {31'h0, MemBusy}, 32'h0);
        issue(32'h1000, 32'h0, 2'b11, 2'b00);
        check("flt_oor_load", {31'h0, MemFault}, 32'h1);
        issue(32'h1000, 32'hFFFFFFFF, 2'b00, 2'b11);
        check("flt_oor_store", {31'h0, MemFault}, 32'h1);
        issue(32'h20, 32'h0BADF00D, 2'b11, 2'b11);
        check("flt_conflict", {31'h0, MemFault}, 32'h1);
        idle_cycle();
        check("flt_pulse", {31'h0, MemFault}, 32'h0);
        issue(32'h30, 32'h0, 2'b11, 2'b00);
        check("flt_keep30", DataMemOut, 32'hCAFEF00D);
        issue(32'h00, 32'h0, 2'b11, 2'b00);
        check("flt_keep00", DataMemOut, 32'h12345678);
        issue(32'h20, 32'h0, 2'b11, 2'b00);
        check("flt_keep20", DataMemOut, 32'hDEADBEEF);

        // Back-to-back word store then load at full rate.
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            a = 32'h50 + 4 * (i % 3);
            issue(32'(a), v, 2'b00, 2'b11);
            issue(32'(a), 32'h0, 2'b11, 2'b00);
            check("b2b_load", DataMemOut, v);
        end

        // Mixed sub-word traffic checked only by the per-cycle model.
        for (int i = 0; i < 24; i++) begin
            a = 32'h60 + $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: issue(32'(a), $urandom, 2'b00, 2'b01);
                1: issue(32'(a & ~1), $urandom, 2'b00, 2'b10);
                2: issue(32'(a & ~3), $urandom, 2'b00, 2'b11);
                default: issue(32'(a), 32'h0, 2'($urandom_range(1, 3)), 2'b00);
            endcase
        end

        idle_cycle();
        idle_cycle();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
